// File: rtl/pac_game_pkg.sv
// ============================================================================
// Module   : pac_game_pkg
// Brief    : Shared state encoding and coordinate widths for the game controller
// Revision : 1.0
// ============================================================================
`default_nettype none

package pac_game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PLAY  = 3'd1,
    ST_DYING = 3'd2,
    ST_OVER  = 3'd3,
    ST_WIN   = 3'd4
  } state_t;

  localparam int X_W          = 10;
  localparam int Y_W          = 9;
  localparam int HIT_DIST_DEF = 16;

endpackage

`default_nettype wire

// File: rtl/pac_hit_det.sv
// ============================================================================
// Module   : pac_hit_det
// Brief    : Combinational hit-box test of one ghost against Pac-Man
// Revision : 1.0
// ============================================================================
`default_nettype none

module pac_hit_det
  import pac_game_pkg::*;
#(
  parameter int HIT_DIST = HIT_DIST_DEF
) (
  input  logic [X_W-1:0] i_pac_x,
  input  logic [X_W-1:0] i_pac_y,
  input  logic [X_W-1:0] i_ghost_x,
  input  logic [Y_W-1:0] i_ghost_y,
  output logic           o_hit
);

  localparam logic [X_W:0] c_DIST = (X_W+1)'(HIT_DIST);

  logic [X_W-1:0] w_gy;
  logic [X_W-1:0] w_dx;
  logic [X_W-1:0] w_dy;

  assign w_gy  = {{(X_W-Y_W){1'b0}}, i_ghost_y};
  assign w_dx  = (i_pac_x >= i_ghost_x) ? (i_pac_x - i_ghost_x) : (i_ghost_x - i_pac_x);
  assign w_dy  = (i_pac_y >= w_gy) ? (i_pac_y - w_gy) : (w_gy - i_pac_y);
  // Strict less-than: a distance of exactly HIT_DIST is a near miss.
  assign o_hit = ({1'b0, w_dx} < c_DIST) && ({1'b0, w_dy} < c_DIST);

endmodule

`default_nettype wire

// File: rtl/pac_game_ctrl.sv
// ============================================================================
// Module   : pac_game_ctrl
// Brief    : Game-state FSM: N-ghost collisions, lives, death freeze, win/over.
//            Optional power-pellet mode enabled by defining PAC_POWER_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pac_game_ctrl
  import pac_game_pkg::*;
#(
  parameter int N_GHOST      = 4,
  parameter int HIT_DIST     = HIT_DIST_DEF,
  parameter int LIVES        = 3,
  parameter int FREEZE_TICKS = 60,
  parameter int LW           = 3
`ifdef PAC_POWER_EN
  ,
  parameter int POWER_TICKS  = 300
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  input  logic                   start,
  input  logic [X_W-1:0]         pac_x,
  input  logic [X_W-1:0]         pac_y,
  input  logic [X_W*N_GHOST-1:0] ghost_x,
  input  logic [Y_W*N_GHOST-1:0] ghost_y,
  input  logic                   all_eaten,
`ifdef PAC_POWER_EN
  input  logic                   power,
  output logic                   frightened,
  output logic [N_GHOST-1:0]     ghost_eaten,
`endif
  output logic [2:0]             state,
  output logic [LW-1:0]          lives,
  output logic [N_GHOST-1:0]     hit_vec,
  output logic                   freeze,
  output logic                   respawn,
  output logic                   over
);

  localparam int            TW       = 16;
  localparam logic [TW-1:0] c_FREEZE = (FREEZE_TICKS == 0) ? TW'(1) : TW'(FREEZE_TICKS);
  localparam logic [LW-1:0] c_LIVES  = LW'(LIVES);

  state_t               r_state, w_state_nx;
  logic [LW-1:0]        r_lives, w_lives_nx;
  logic [TW-1:0]        r_timer, w_timer_nx;
  logic                 r_respawn, w_respawn_nx;
  logic [N_GHOST-1:0]   r_hit_vec, w_hit_raw, w_hit_eff;

  for (genvar i = 0; i < N_GHOST; i++) begin : g_hit
    pac_hit_det #(.HIT_DIST(HIT_DIST)) u_det (
      .i_pac_x   (pac_x),
      .i_pac_y   (pac_y),
      .i_ghost_x (ghost_x[X_W*i +: X_W]),
      .i_ghost_y (ghost_y[Y_W*i +: Y_W]),
      .o_hit     (w_hit_raw[i])
    );
  end

`ifdef PAC_POWER_EN
  localparam logic [15:0] c_POWER = 16'(POWER_TICKS);

  logic [15:0]        r_ptimer;
  logic [N_GHOST-1:0] r_eaten, r_ghost_eaten;
  logic               w_fright_play;

  assign frightened    = (r_ptimer != '0);
  assign w_fright_play = frightened && (r_state == ST_PLAY);
  // An eaten ghost stays harmless until it separates from Pac-Man.
  assign w_hit_eff     = w_fright_play ? '0 : (r_hit_vec & ~r_eaten);
  assign ghost_eaten   = r_ghost_eaten;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptimer      <= '0;
      r_eaten       <= '0;
      r_ghost_eaten <= '0;
    end else begin
      r_ghost_eaten <= w_fright_play ? (r_hit_vec & ~r_eaten) : '0;
      r_eaten       <= (r_eaten & r_hit_vec) | (w_fright_play ? r_hit_vec : '0);
      if ((r_state != ST_PLAY) || (w_state_nx != ST_PLAY))
        r_ptimer <= '0;
      else if (power)
        r_ptimer <= c_POWER;
      else if (tick && frightened)
        r_ptimer <= r_ptimer - 16'd1;
    end
  end
`else
  assign w_hit_eff = r_hit_vec;
`endif

  always_comb begin
    w_state_nx   = r_state;
    w_lives_nx   = r_lives;
    w_timer_nx   = r_timer;
    w_respawn_nx = 1'b0;
    case (r_state)
      ST_IDLE, ST_OVER, ST_WIN: begin
        if (start) begin
          w_state_nx   = ST_PLAY;
          w_lives_nx   = c_LIVES;
          w_respawn_nx = 1'b1;
        end
      end
      ST_PLAY: begin
        if (all_eaten) begin
          w_state_nx = ST_WIN;
        end else if (|w_hit_eff) begin
          if (r_lives <= LW'(1)) begin
            w_lives_nx = '0;
            w_state_nx = ST_OVER;
          end else begin
            w_lives_nx = r_lives - LW'(1);
            w_timer_nx = c_FREEZE;
            w_state_nx = ST_DYING;
          end
        end
      end
      ST_DYING: begin
        if (tick) begin
          if (r_timer <= TW'(1)) begin
            w_timer_nx   = '0;
            w_respawn_nx = 1'b1;
            w_state_nx   = ST_PLAY;
          end else begin
            w_timer_nx = r_timer - TW'(1);
          end
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_lives   <= '0;
      r_timer   <= '0;
      r_respawn <= 1'b0;
      r_hit_vec <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_lives   <= w_lives_nx;
      r_timer   <= w_timer_nx;
      r_respawn <= w_respawn_nx;
      r_hit_vec <= w_hit_raw;
    end
  end

  assign state   = r_state;
  assign lives   = r_lives;
  assign hit_vec = r_hit_vec;
  assign respawn = r_respawn;
  assign freeze  = (r_state != ST_PLAY);
  assign over    = (r_state == ST_OVER) || (r_state == ST_WIN);

endmodule

`default_nettype wire
